// File: rtl/wide_addsub_seq.sv
`default_nettype none
// ============================================================================
// wide_addsub_seq : word-serial W-bit add/sub over a shared external N-bit adder.
// Optional flags (rsp_zero_o, rsp_ovf_o) enabled by WIDE_ADDSUB_FLAGS_EN.
// Revision: 1.0
// ============================================================================
module wide_addsub_seq #(
  parameter int N     = 32,
  parameter int WORDS = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_sub_i,
  input  logic [N*WORDS-1:0]   req_opa_i,
  input  logic [N*WORDS-1:0]   req_opb_i,
  input  logic                 flush_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [N*WORDS-1:0]   rsp_res_o,
  output logic                 rsp_carry_o,
  output logic [N-1:0]         add_opa_o,
  output logic [N-1:0]         add_opb_o,
  output logic                 add_carry_o,
  output logic                 add_inv_b_o,
  input  logic [N-1:0]         add_res_i,
  input  logic                 add_carry_i
`ifdef WIDE_ADDSUB_FLAGS_EN
  ,
  output logic                 rsp_zero_o,
  output logic                 rsp_ovf_o
`endif
);

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [WORDS-1:0][N-1:0]  opa_q, opa_d;
  logic [WORDS-1:0][N-1:0]  opb_q, opb_d;
  logic [WORDS-1:0][N-1:0]  res_q, res_d;
  logic                     sub_q, sub_d;
  logic                     carry_q, carry_d;
  logic                     c_eff;
`ifdef WIDE_ADDSUB_FLAGS_EN
  logic                     msb_cin_q, msb_cin_d;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    c_eff       = 1'b0;
    add_opa_o   = '0;
    add_opb_o   = '0;
    add_carry_o = 1'b0;
    add_inv_b_o = 1'b0;
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == DONE);
`ifdef WIDE_ADDSUB_FLAGS_EN
    msb_cin_d   = msb_cin_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          opa_d   = req_opa_i;
          opb_d   = req_opb_i;
          sub_d   = req_sub_i;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The adder adds inv_b to its carry-in, so pre-cancel it here.
        c_eff       = (k_q == '0) ? sub_q : carry_q;
        add_opa_o   = opa_q[k_q];
        add_opb_o   = opb_q[k_q];
        add_inv_b_o = sub_q;
        add_carry_o = c_eff ^ sub_q;
        res_d[k_q]  = add_res_i;
        carry_d     = add_carry_i;
        if (k_q == K_LAST) begin
`ifdef WIDE_ADDSUB_FLAGS_EN
          msb_cin_d = opa_q[k_q][N-1] ^ opb_q[k_q][N-1] ^ sub_q ^ add_res_i[N-1];
`endif
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d = IDLE;
      k_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      k_q       <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
`ifdef WIDE_ADDSUB_FLAGS_EN
      msb_cin_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      sub_q     <= sub_d;
      carry_q   <= carry_d;
`ifdef WIDE_ADDSUB_FLAGS_EN
      msb_cin_q <= msb_cin_d;
`endif
    end
  end

  assign rsp_res_o   = res_q;
  assign rsp_carry_o = carry_q;

`ifdef WIDE_ADDSUB_FLAGS_EN
  assign rsp_zero_o = (state_q == DONE) && (res_q == '0);
  assign rsp_ovf_o  = (state_q == DONE) && (msb_cin_q ^ carry_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_wide_addsub_seq.sv
`default_nettype none
// Self-checking bench for wide_addsub_seq (N=32, WORDS=2) with a behavioural
// adder on the add_* port and an arithmetic reference model.
module tb_wide_addsub_seq;

  localparam int N     = 32;
  localparam int WORDS = 2;
  localparam int W     = N * WORDS;

  logic           clk = 1'b0;
  logic           rstn;
  logic           req_valid, req_ready, req_sub, flush;
  logic [W-1:0]   req_opa, req_opb;
  logic           rsp_valid, rsp_ready, rsp_carry;
  logic [W-1:0]   rsp_res;
  logic [N-1:0]   add_opa, add_opb, add_res;
  logic           add_carry, add_inv_b, add_cout;
`ifdef WIDE_ADDSUB_FLAGS_EN
  logic           rsp_zero, rsp_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wide_addsub_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_sub_i   (req_sub),
    .req_opa_i   (req_opa),
    .req_opb_i   (req_opb),
    .flush_i     (flush),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_res_o   (rsp_res),
    .rsp_carry_o (rsp_carry),
    .add_opa_o   (add_opa),
    .add_opb_o   (add_opb),
    .add_carry_o (add_carry),
    .add_inv_b_o (add_inv_b),
    .add_res_i   (add_res),
    .add_carry_i (add_cout)
`ifdef WIDE_ADDSUB_FLAGS_EN
    ,
    .rsp_zero_o  (rsp_zero),
    .rsp_ovf_o   (rsp_ovf)
`endif
  );

  // External adder: inverts opb on inv_b, effective carry-in = carry ^ inv_b.
  logic [N:0] add_sum;
  assign add_sum  = {1'b0, add_opa} + {1'b0, (add_inv_b ? ~add_opb : add_opb)}
                  + {{N{1'b0}}, add_carry ^ add_inv_b};
  assign add_res  = add_sum[N-1:0];
  assign add_cout = add_sum[N];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // True carry into word j of the wide operation.
  function automatic logic ref_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input int j);
    logic [W:0] mask, al, bl, sum;
    if (j == 0) return s;
    mask = ({{W{1'b0}}, 1'b1} << (N * j)) - 1'b1;
    al   = {1'b0, a} & mask;
    bl   = {1'b0, b} & mask;
    if (s) return (al >= bl);
    sum = al + bl;
    return sum[N * j];
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int hold);
    logic [W:0]   full;
    logic [W-1:0] exp_res;
    logic         exp_c, exp_ovf;
    int           cyc;
    full    = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    exp_res = full[W-1:0];
    exp_c   = s ? (a >= b) : full[W];
    exp_ovf = s ? ((a[W-1] != b[W-1]) && (exp_res[W-1] != a[W-1]))
                : ((a[W-1] == b[W-1]) && (exp_res[W-1] != a[W-1]));

    @(negedge clk);
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_opa = a; req_opb = b; req_sub = s;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      if (cyc < WORDS) begin
        check("run_opa",   {32'd0, add_opa}, {32'd0, a[cyc*N +: N]});
        check("run_inv_b", {63'd0, add_inv_b}, {63'd0, s});
        check("run_carry", {63'd0, add_carry}, {63'd0, ref_cin(a, b, s, cyc) ^ s});
      end
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(WORDS));
    check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("rsp_res", rsp_res, exp_res);
    check("rsp_carry", {63'd0, rsp_carry}, {63'd0, exp_c});
    check("add_idle_done", {31'd0, add_opa, add_carry}, 64'd0);
`ifdef WIDE_ADDSUB_FLAGS_EN
    check("rsp_zero", {63'd0, rsp_zero}, {63'd0, (exp_res == '0)});
    check("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, exp_ovf});
`else
    if (exp_ovf && 1'b0) $display("unused");
`endif
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_opa = ~a; req_opb = b; req_sub = ~s;
      @(negedge clk);
      check("hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_res", rsp_res, exp_res);
      check("hold_ready", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_valid", {63'd0, rsp_valid}, 64'd0);
    check("post_ready", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    rstn = 1'b0; req_valid = 1'b0; req_sub = 1'b0; flush = 1'b0;
    req_opa = '0; req_opb = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_res", rsp_res, 64'd0);
    check("rst_carry", {63'd0, rsp_carry}, 64'd0);
    check("rst_add", {29'd0, add_opa, add_opb[0], add_carry, add_inv_b}, 64'd0);
    rstn = 1'b1;

    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0);
    run_op(64'd0, 64'd1, 1'b1, 0);
    run_op(64'd5, 64'd5, 1'b1, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 5);

    // Flush in the first RUN cycle.
    @(negedge clk);
    req_valid = 1'b1; req_opa = 64'd100; req_opb = 64'd7; req_sub = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("flush_in_run", {63'd0, req_ready}, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("flush_novalid", 64'(seen), 64'd0);
    check("flush_ready", {63'd0, req_ready}, 64'd1);
    run_op(64'd100, 64'd7, 1'b1, 1);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    req_valid = 1'b1; req_opa = 64'h1234_5678_9ABC_DEF0; req_opb = 64'd3; req_sub = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_run_opa", {32'd0, add_opa}, 64'h9ABC_DEF0);
    rstn = 1'b0;
    #1;
    check("arst_opa", {32'd0, add_opa}, 64'd0);
    check("arst_res", rsp_res, 64'd0);
    check("arst_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("arst_ready", {63'd0, req_ready}, 64'd1);
    check("arst_valid2", {63'd0, rsp_valid}, 64'd0);

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 5 == 0) b = a;
      if (i % 7 == 1) a[N-1:0] = '1;
      run_op(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
